pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 32, width of the ALU/result payload.
REQ-002 Parameter SEL_W, 5, width of the register write-select field.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port flush  input  1  synchronous squash of all held entries.
REQ-006 Port in_valid  input  1  upstream offers a payload.
REQ-007 Port in_ready  output  1  stage accepts a payload this cycle.
REQ-008 Port in_data  input  DATA_W  upstream result.
REQ-009 Port in_sel  input  SEL_W  upstream write-select.
REQ-010 Port in_we  input  1  upstream write-enable.
REQ-011 Port out_valid  output  1  stage holds a payload for downstream.
REQ-012 Port out_ready  input  1  downstream accepts this cycle.
REQ-013 Port out_data  output  DATA_W  held result.
REQ-014 Port out_sel  output  SEL_W  held write-select.
REQ-015 Port out_we  output  1  held write-enable, qualified by out_valid.

Function
REQ-016 The payload SHALL be {data, sel, we}; an input transfer occurs when in_valid and in_ready are both 1 at a clock edge; an output transfer occurs when out_valid and out_ready are both 1 at a clock edge.
REQ-017 Latency SHALL be one cycle: a payload accepted into an empty stage appears on the out_* ports after that edge.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sel and out_we SHALL hold their values unchanged.
REQ-019 out_we SHALL be 0 whenever out_valid is 0, so no spurious register-file write can occur.
REQ-020 Payloads SHALL leave in acceptance order, with none lost and none duplicated.
REQ-021 flush=1 SHALL clear every held entry at the next edge (out_valid=0, out_we=0) and discard any input transfer in the same cycle; flush takes priority over all other events.
REQ-022 A simultaneous input and output transfer SHALL replace the output payload with the new one at the edge.
REQ-023 State machine: EMPTY (no entry), FULL (main entry only), SKID (main and skid entries; exists only with the skid option).
REQ-024 Transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input; FULL->SKID on input transfer while out_ready=0; SKID->FULL on output transfer, with the skid entry moving to main; any state->EMPTY on flush.

Reset
REQ-025 While rst=1, the block SHALL immediately, independent of clk, force state=EMPTY and out_valid=0, out_data=0, out_sel=0 and out_we=0; the skid entry SHALL be cleared.
REQ-026 in_ready SHALL read 1 during and after reset.
REQ-027 Reset asserted mid-transfer SHALL discard all held payloads; the first edge after rst deasserts behaves as EMPTY.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: a 2-entry skid buffer is included; in_ready SHALL be registered (in_ready = not SKID), with no combinational path from out_ready to in_ready and full throughput sustained.
REQ-029 Macro PIPE_STAGE_SKID_EN undefined: there is no SKID state; in_ready SHALL equal (not out_valid) or out_ready combinationally.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the default DATA_W/SEL_W constants, the state encoding (EMPTY/FULL/SKID) and a payload struct typedef.
REQ-031 The skid entry SHALL be a sub-module pipe_skid_buf (payload register plus valid bit, async reset), instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-032 Reset: rst pulsed between clock edges -> all outputs 0 immediately, in_ready=1.
REQ-033 Single beat: in_data=0xDEADBEEF, in_sel=5'd7, in_we=1 accepted with out_ready=1 -> the same values on the outputs one cycle later, then out_valid=0 and out_we=0.
REQ-034 Backpressure: stream 1,2,3 with out_ready=0 for 3 cycles -> outputs hold 1; with skid, in_ready drops after 2 accepts; then 1,2,3 drain in order with none lost.
REQ-035 Flush: stage FULL with 0x55, in_valid=1 with 0x66, flush=1 -> next cycle out_valid=0 and 0x66 never appears.
REQ-036 Throughput: continuous in_valid with out_ready=1 for 16 cycles -> 16 outputs in 16 cycles, in_ready constantly 1.
REQ-037 Async reset from SKID state -> EMPTY immediately; the next input is accepted normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the result pipeline stage: default widths, state encoding, payload layout.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_SEL_W  = 5;

   // SKID is only reachable when the skid buffer is built in.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_e;

   // Payload at the default widths; field order {data, sel, we}.
   typedef struct packed {
      logic [PIPE_DATA_W-1:0] data;
      logic [PIPE_SEL_W-1:0]  sel;
      logic                   we;
   } pipe_payload_t;

   // A write-enable may only reach the register file alongside a valid payload.
   function automatic logic qualify_we(input logic we, input logic vld);
      return we & vld;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry: one payload register plus valid bit, used when the main entry is stalled.
// Latency: one cycle from load to q/vld.
// Backpressure: none of its own; the owning stage decides when to load or clear.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset (clears payload and valid)
//   clr        synchronous clear, wins over load
//   load       capture d and set vld
//   d, q, vld  payload in, held payload out, entry occupied
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int W = PIPE_DATA_W + PIPE_SEL_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         vld
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= '0;
         vld <= 1'b0;
      end else if (clr) begin
         q   <= '0;
         vld <= 1'b0;
      end else if (load) begin
         q   <= d;
         vld <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register for {data, sel, we} between ALU result and register-file write.
// Latency: one cycle from input transfer to out_* ports.
// Backpressure: default build passes out_ready through to in_ready combinationally; with
//   PIPE_STAGE_SKID_EN defined a skid entry absorbs one extra beat so in_ready comes from
//   state flops only, keeping full throughput without an out_ready->in_ready path.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   flush                          synchronous squash of all held entries (highest priority)
//   in_valid/in_ready              upstream handshake
//   in_data/in_sel/in_we           upstream payload
//   out_valid/out_ready            downstream handshake
//   out_data/out_sel/out_we        held payload; out_we is forced low while out_valid is low
//
// Configuration macro: PIPE_STAGE_SKID_EN (undefined by default).
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int SEL_W  = PIPE_SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_sel,
   output logic              out_we
);

   // Local payload layout at the instance widths (same field order as pipe_payload_t).
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SEL_W-1:0]  sel;
      logic              we;
   } pld_t;

   pipe_state_e state_q, state_d;
   pld_t        main_q, main_d;
   pld_t        in_pld;
   logic        in_xfer;
   logic        out_xfer;

   assign in_pld   = {in_data, in_sel, in_we};
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   localparam int PLD_W = $bits(pld_t);

   logic             skid_load;
   logic             skid_clr;
   logic             skid_vld;
   logic [PLD_W-1:0] skid_q;

   pipe_skid_buf #(.W(PLD_W)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .clr  (skid_clr),
      .load (skid_load),
      .d    (in_pld),
      .q    (skid_q),
      .vld  (skid_vld)
   );

   // Decoded from the state flop only, so it never depends on out_ready this cycle.
   assign in_ready = (state_q != ST_SKID);
`else
   // Accept when empty, or when the held payload leaves at the same edge.
   assign in_ready = ~out_valid | out_ready;
`endif

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_load = 1'b0;
      skid_clr  = 1'b0;
`endif
      if (flush) begin
         // Squash everything, including a transfer offered in the same cycle.
         state_d = ST_EMPTY;
         main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_clr = 1'b1;
`endif
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d = ST_FULL;
                  main_d  = in_pld;
               end
            end
            ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
               if (in_xfer && !out_xfer) begin
                  // Downstream stalled: park the new beat behind the main entry.
                  state_d   = ST_SKID;
                  skid_load = 1'b1;
               end else if (in_xfer) begin
                  main_d = in_pld;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
`else
               // in_ready already implies out_ready here, so an input transfer is
               // always a simultaneous replace.
               if (in_xfer) begin
                  main_d = in_pld;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_SKID: begin
               // in_ready is low here, so only the drain of main can happen.
               if (out_xfer && skid_vld) begin
                  state_d  = ST_FULL;
                  main_d   = pld_t'(skid_q);
                  skid_clr = 1'b1;
               end
            end
`endif
            default: begin
               state_d = ST_EMPTY;
               main_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q.data;
   assign out_sel   = main_q.sel;
   assign out_we    = qualify_we(main_q.we, out_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: queue model of the stage plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_stage_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_sel;
   logic        in_we;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_sel;
   logic        out_we;

   pipe_stage_reg #(.DATA_W(32), .SEL_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_we     (in_we),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_we    (out_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: FIFO of accepted payloads {data, sel, we}; head is what must be on out_*.
   logic [37:0] mq[$];
   logic [31:0] dut_seen[$];
   int          out_cnt;
   int          ir_low;
   bit          seen66;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ir();
`ifdef PIPE_STAGE_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || out_ready;
`endif
   endfunction

   task automatic compare();
      logic [37:0] e;
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, model_ir()});
      if (mq.size() > 0) begin
         e = mq[0];
         check("out_data", out_data, e[37:6]);
         check("out_sel", {27'd0, out_sel}, {27'd0, e[5:1]});
         check("out_we", {31'd0, out_we}, {31'd0, e[0]});
      end else begin
         check("out_we_idle", {31'd0, out_we}, 32'd0);
      end
      if (out_valid && out_ready) begin
         dut_seen.push_back(out_data);
         out_cnt++;
      end
      if (out_valid && out_data == 32'h66) seen66 = 1'b1;
      if (in_valid && !in_ready) ir_low++;
   endtask

   // One clock: drive, compare at negedge, advance the model at posedge, return at posedge+1.
   task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] s, input logic w,
                      input logic ordy, input logic fl, output bit acc);
      logic ir;
      bit   ox;
      in_valid  = v;
      in_data   = d;
      in_sel    = s;
      in_we     = w;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      compare();
      @(posedge clk);
      ir  = model_ir();
      acc = 1'b0;
      if (flush) begin
         mq.delete();
      end else begin
         ox  = (mq.size() > 0) && out_ready;
         acc = in_valid && ir;
         if (ox) void'(mq.pop_front());
         if (acc) mq.push_back({in_data, in_sel, in_we});
      end
      #1;
   endtask

   task automatic pulse_rst();
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_we", {31'd0, out_we}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_sel", {27'd0, out_sel}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      #1 rst = 1'b0;
      mq.delete();
   endtask

   initial begin
      bit acc;
      int nxt;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      in_we     = 1'b0;
      out_ready = 1'b0;
      out_cnt   = 0;
      ir_low    = 0;
      seen66    = 1'b0;

      // Power-on reset
      @(posedge clk);
      #2;
      check("por_out_valid", {31'd0, out_valid}, 32'd0);
      check("por_out_data", out_data, 32'd0);
      check("por_in_ready", {31'd0, in_ready}, 32'd1);
      #1 rst = 1'b0;

      // Single beat
      cyc(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1, 1'b0, acc);
      check("beat_acc", {31'd0, acc}, 32'd1);
      check("beat_valid", {31'd0, out_valid}, 32'd1);
      check("beat_data", out_data, 32'hDEADBEEF);
      check("beat_sel", {27'd0, out_sel}, 32'd7);
      check("beat_we", {31'd0, out_we}, 32'd1);
      cyc(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
      check("beat_gone_valid", {31'd0, out_valid}, 32'd0);
      check("beat_gone_we", {31'd0, out_we}, 32'd0);

      // Backpressure: three stalled cycles, then drain
      dut_seen.delete();
      nxt = 0;
      for (int c = 0; c < 3; c++) begin
         cyc(nxt < 3, 32'(nxt + 1), 5'(nxt + 1), 1'b1, 1'b0, 1'b0, acc);
         if (acc) nxt++;
      end
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", out_data, 32'd1);
`ifdef PIPE_STAGE_SKID_EN
      check("bp_accepts", nxt, 32'd2);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
`else
      check("bp_accepts", nxt, 32'd1);
`endif
      for (int c = 0; c < 20 && (nxt < 3 || dut_seen.size() < 3); c++) begin
         cyc(nxt < 3, 32'(nxt + 1), 5'(nxt + 1), 1'b1, 1'b1, 1'b0, acc);
         if (acc) nxt++;
      end
      check("bp_drain_count", dut_seen.size(), 32'd3);
      for (int i = 0; i < 3 && i < dut_seen.size(); i++)
         check("bp_order", dut_seen[i], 32'(i + 1));

      // Flush with a competing input transfer
      cyc(1'b1, 32'h55, 5'd2, 1'b1, 1'b0, 1'b0, acc);
      check("fl_load", out_data, 32'h55);
      seen66 = 1'b0;
      cyc(1'b1, 32'h66, 5'd3, 1'b1, 1'b1, 1'b1, acc);
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      check("fl_we", {31'd0, out_we}, 32'd0);
      for (int c = 0; c < 3; c++) cyc(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
      check("fl_no_66", {31'd0, seen66}, 32'd0);

      // Throughput: 16 back-to-back beats
      out_cnt = 0;
      ir_low  = 0;
      dut_seen.delete();
      for (int i = 0; i < 16; i++)
         cyc(1'b1, 32'(100 + i), 5'(i), i[0], 1'b1, 1'b0, acc);
      cyc(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
      check("tp_outputs", out_cnt, 32'd16);
      check("tp_in_ready_low", ir_low, 32'd0);
      check("tp_first", dut_seen.size() > 0 ? dut_seen[0] : 32'hFFFF_FFFF, 32'd100);

      // Async reset with the stage loaded (SKID when the skid buffer exists)
      cyc(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, acc);
      cyc(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, acc);
      check("pre_rst_data", out_data, 32'h11);
      pulse_rst();
      cyc(1'b1, 32'hA5, 5'd3, 1'b1, 1'b1, 1'b0, acc);
      check("post_rst_acc", {31'd0, acc}, 32'd1);
      check("post_rst_data", out_data, 32'hA5);
      check("post_rst_we", {31'd0, out_we}, 32'd1);
      cyc(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
      cyc(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
      check("final_empty", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
